floo_vc_input_buffer: RTL

Per-input-port virtual-channel buffer of the VC router, directly upstream of the round-robin switch arbiter.
- Stores incoming flits in one circular FIFO per VC.
- Presents a request vector of non-empty VCs, plus their head flits, to the arbiter.
- Pops the VC the arbiter granted.
- Returns one credit per freed slot to the upstream router.
- Flow control is credit-based: there is no ready towards upstream.

---
 rtl/floo_vc_pkg.sv | 15 +
 rtl/floo_vc_fifo.sv | 78 +++++++
 rtl/floo_vc_input_buffer.sv | 81 ++++++++
 3 files changed

// File: rtl/floo_vc_pkg.sv
// Shared VC router types: VC id type and default buffer geometry.
package floo_vc_pkg;

    localparam int unsigned DefaultNumVC   = 4;
    localparam int unsigned DefaultVCDepth = 2;

    function automatic int unsigned vc_id_width(input int unsigned num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    localparam int unsigned DefaultNumVCWidth = vc_id_width(DefaultNumVC);

    typedef logic [DefaultNumVCWidth-1:0] vc_id_t;

endpackage

// File: rtl/floo_vc_fifo.sv
// Single-VC circular flit buffer with registered head and occupancy.
// FLOO_VC_BUF_OVERFLOW_CHECK_EN drops overflowing pushes and raises a sticky flag.
module floo_vc_fifo
    import floo_vc_pkg::*;
#(
    parameter int unsigned Depth     = DefaultVCDepth,
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [DataWidth-1:0] head_o,
    output logic                 not_empty_o,
    output logic                 full_o,
    output logic                 overflow_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [Depth-1:0][DataWidth-1:0] mem_q;
    logic [PtrWidth-1:0]             wr_q, rd_q;
    logic [CntWidth-1:0]             cnt_q;
    logic                            push_ok;

    // Explicit wrap keeps non-power-of-two depths inside the array.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full_o      = (cnt_q == CntWidth'(Depth));
    assign not_empty_o = (cnt_q != '0);
    assign head_o      = mem_q[rd_q];

`ifdef FLOO_VC_BUF_OVERFLOW_CHECK_EN
    logic ovf_q;

    // A full VC still accepts a push when it pops in the same cycle.
    assign push_ok    = push_i && !(full_o && !pop_i);
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (push_i && full_o && !pop_i) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign push_ok    = push_i;
    assign overflow_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= next_ptr(wr_q);
            end
            if (pop_i) begin
                rd_q <= next_ptr(rd_q);
            end
            case ({push_ok, pop_i})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/floo_vc_input_buffer.sv
// Per-input-port VC buffer: one FIFO per VC, arbiter request/head view, credit return.
// FLOO_VC_BUF_OVERFLOW_CHECK_EN enables overflow drop and the sticky overflow_o flag.
module floo_vc_input_buffer
    import floo_vc_pkg::*;
#(
    parameter int unsigned NumVC     = DefaultNumVC,
    parameter int unsigned VCDepth   = DefaultVCDepth,
    parameter int unsigned DataWidth = 64,
    localparam int unsigned NumVCWidth = vc_id_width(NumVC)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    input  logic [NumVCWidth-1:0]      vc_id_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic [NumVC-1:0]           vc_req_o,
    output logic [NumVC*DataWidth-1:0] vc_data_o,
    input  logic                       pop_valid_i,
    input  logic [NumVCWidth-1:0]      pop_id_i,
    output logic                       credit_v_o,
    output logic [NumVCWidth-1:0]      credit_id_o,
    output logic                       overflow_o
);

    logic [NumVC-1:0] push_v, pop_v, full_v, ovf_v;
    logic             pop_any;
    logic             credit_v_q;
    logic [NumVCWidth-1:0] credit_id_q;

    for (genvar v = 0; v < NumVC; v++) begin : g_vc
        assign push_v[v] = valid_i && (vc_id_i == NumVCWidth'(v));
        // Ids beyond NumVC never match, so such pops are ignored.
        assign pop_v[v]  = pop_valid_i && (pop_id_i == NumVCWidth'(v)) && vc_req_o[v];

        floo_vc_fifo #(
            .Depth     (VCDepth),
            .DataWidth (DataWidth)
        ) i_fifo (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .push_i      (push_v[v]),
            .pop_i       (pop_v[v]),
            .data_i      (data_i),
            .head_o      (vc_data_o[v*DataWidth +: DataWidth]),
            .not_empty_o (vc_req_o[v]),
            .full_o      (full_v[v]),
            .overflow_o  (ovf_v[v])
        );

`ifdef FLOO_VC_BUF_OVERFLOW_CHECK_EN
`ifndef SYNTHESIS
        always_ff @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(push_v[v] && full_v[v] && !pop_v[v]))
                    else $warning("floo_vc_input_buffer: overflowing push dropped on VC %0d", v);
            end
        end
`endif
`endif
    end

    assign pop_any    = |pop_v;
    assign overflow_o = |ovf_v;

    // Credit id holds its last value between pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credit_v_q  <= 1'b0;
            credit_id_q <= '0;
        end else begin
            credit_v_q <= pop_any;
            if (pop_any) begin
                credit_id_q <= pop_id_i;
            end
        end
    end

    assign credit_v_o  = credit_v_q;
    assign credit_id_o = credit_id_q;

endmodule
